// File: rtl/bus_master_arb.sv
// Bus ownership arbiter: debug port, NINT internal masters and the host CPU.
// Define BUS_ARB_RR_EN for round-robin among internal masters (default: fixed priority, bit 0 first).
module bus_master_arb #(
  parameter int NINT     = 3,
  parameter int TURN     = 1,
  parameter int MAXTEN   = 64,
  parameter int PARK_CPU = 1
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            clken,
  input  logic            cpureq,
  input  logic            dbgreq,
  input  logic [NINT-1:0] intreq,
  input  logic            idle,
  input  logic            ack,
  output logic            cpubm,
  output logic            dbggnt,
  output logic [NINT-1:0] intgnt,
  output logic            intbm,
  output logic            notdbg,
  output logic            relreq,
  output logic [1:0]      owner
);

  localparam int IW = (NINT > 1) ? $clog2(NINT) : 1;

  typedef enum logic [1:0] {S_PARK, S_TURNA, S_OWN, S_TURNB} state_e;
  typedef enum logic [1:0] {W_NONE = 2'd0, W_CPU = 2'd1, W_DBG = 2'd2, W_INT = 2'd3} who_e;

  state_e          state_q, state_d;
  who_e            who_q, who_d;
  logic [1:0]      turn_q, turn_d;
  logic [7:0]      ten_q, ten_d;
  logic [NINT-1:0] win_oh_q, win_oh_d;
  logic            cpu_q, cpu_d;
  logic            dbg_q, dbg_d;
  logic [NINT-1:0] int_q, int_d;
  logic            rel_q, rel_d;

  logic [NINT-1:0] sel_oh;
  logic            int_hit;
  logic            own_req;
  logic            other_pending;
  logic            turn_done;

`ifdef BUS_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_idx_q, win_idx_d;
  logic [IW-1:0] sel_idx;
`endif

  assign int_hit   = |intreq;
  assign turn_done = (turn_q == 2'(TURN - 1));

  always_comb begin : int_select
    logic found;
    found  = 1'b0;
    sel_oh = '0;
`ifdef BUS_ARB_RR_EN
    sel_idx = '0;
    // First pass covers indices after the last grant, second pass wraps to 0.
    for (int k = 0; k < NINT; k++) begin
      if (!found && intreq[k] && (k > int'(ptr_q))) begin
        found     = 1'b1;
        sel_oh[k] = 1'b1;
        sel_idx   = IW'(k);
      end
    end
    for (int k = 0; k < NINT; k++) begin
      if (!found && intreq[k]) begin
        found     = 1'b1;
        sel_oh[k] = 1'b1;
        sel_idx   = IW'(k);
      end
    end
`else
    for (int k = 0; k < NINT; k++) begin
      if (!found && intreq[k]) begin
        found     = 1'b1;
        sel_oh[k] = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    own_req       = 1'b0;
    other_pending = 1'b0;
    case (who_q)
      W_CPU: begin
        own_req       = cpureq;
        other_pending = dbgreq | int_hit;
      end
      W_DBG: begin
        own_req       = dbgreq;
        other_pending = cpureq | int_hit;
      end
      W_INT: begin
        own_req       = |(intreq & int_q);
        other_pending = dbgreq | cpureq | (|(intreq & ~int_q));
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    who_d    = who_q;
    turn_d   = turn_q;
    ten_d    = ten_q;
    win_oh_d = win_oh_q;
    cpu_d    = cpu_q;
    dbg_d    = dbg_q;
    int_d    = int_q;
    rel_d    = rel_q;
`ifdef BUS_ARB_RR_EN
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
`endif
    case (state_q)
      S_PARK: begin
        if ((dbgreq || int_hit || cpureq) && idle && !ack) begin
          if ((PARK_CPU != 0) && cpu_q && cpureq && !dbgreq && !int_hit) begin
            // Parked CPU as sole requester keeps the bus with no turnaround.
            state_d = S_OWN;
            who_d   = W_CPU;
            ten_d   = '0;
            rel_d   = 1'b0;
          end else begin
            state_d  = S_TURNA;
            turn_d   = '0;
            cpu_d    = 1'b0;
            who_d    = dbgreq ? W_DBG : (int_hit ? W_INT : W_CPU);
            win_oh_d = sel_oh;
`ifdef BUS_ARB_RR_EN
            win_idx_d = sel_idx;
`endif
          end
        end
      end
      S_TURNA: begin
        if (turn_done) begin
          state_d = S_OWN;
          ten_d   = '0;
          rel_d   = 1'b0;
          case (who_q)
            W_CPU: cpu_d = 1'b1;
            W_DBG: dbg_d = 1'b1;
            W_INT: begin
              int_d = win_oh_q;
`ifdef BUS_ARB_RR_EN
              ptr_d = win_idx_q;
`endif
            end
            default: ;
          endcase
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      S_OWN: begin
        if (!own_req && idle && !ack) begin
          state_d = S_TURNB;
          who_d   = W_NONE;
          turn_d  = '0;
          ten_d   = '0;
          rel_d   = 1'b0;
          cpu_d   = 1'b0;
          dbg_d   = 1'b0;
          int_d   = '0;
        end else begin
          if (ten_q != 8'(MAXTEN)) ten_d = ten_q + 8'd1;
          // Sticky until release: the owner is never forcibly revoked.
          rel_d = rel_q | ((ten_d == 8'(MAXTEN)) && other_pending);
        end
      end
      S_TURNB: begin
        if (turn_done) begin
          state_d = S_PARK;
          cpu_d   = (PARK_CPU != 0);
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      default: state_d = S_PARK;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= S_PARK;
      who_q    <= (PARK_CPU != 0) ? W_CPU : W_NONE;
      turn_q   <= '0;
      ten_q    <= '0;
      win_oh_q <= '0;
      cpu_q    <= (PARK_CPU != 0);
      dbg_q    <= 1'b0;
      int_q    <= '0;
      rel_q    <= 1'b0;
`ifdef BUS_ARB_RR_EN
      ptr_q     <= IW'(NINT - 1);
      win_idx_q <= '0;
`endif
    end else if (clken) begin
      state_q  <= state_d;
      who_q    <= who_d;
      turn_q   <= turn_d;
      ten_q    <= ten_d;
      win_oh_q <= win_oh_d;
      cpu_q    <= cpu_d;
      dbg_q    <= dbg_d;
      int_q    <= int_d;
      rel_q    <= rel_d;
`ifdef BUS_ARB_RR_EN
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
`endif
    end
  end

  assign cpubm  = cpu_q;
  assign dbggnt = dbg_q;
  assign intgnt = int_q;
  assign intbm  = |int_q;
  assign notdbg = ~dbg_q;
  assign relreq = rel_q;
  assign owner  = dbg_q ? 2'd2 : ((|int_q) ? 2'd3 : (cpu_q ? 2'd1 : 2'd0));

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed bench for bus_master_arb: two instances (TURN=1 and TURN=2, MAXTEN=4) on shared inputs.
module tb_bus_master_arb;
  localparam int W = 10;

  logic       sys_clk = 1'b0;
  logic       reset, clken, cpureq, dbgreq, idle, ack;
  logic [2:0] intreq;

  logic       cpubm1, dbggnt1, intbm1, notdbg1, relreq1;
  logic [2:0] intgnt1;
  logic [1:0] owner1;
  logic       cpubm2, dbggnt2, intbm2, notdbg2, relreq2;
  logic [2:0] intgnt2;
  logic [1:0] owner2;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  bus_master_arb #(.NINT(3), .TURN(1), .MAXTEN(4), .PARK_CPU(1)) dut (
    .sys_clk(sys_clk), .reset(reset), .clken(clken), .cpureq(cpureq), .dbgreq(dbgreq),
    .intreq(intreq), .idle(idle), .ack(ack), .cpubm(cpubm1), .dbggnt(dbggnt1),
    .intgnt(intgnt1), .intbm(intbm1), .notdbg(notdbg1), .relreq(relreq1), .owner(owner1));

  bus_master_arb #(.NINT(3), .TURN(2), .MAXTEN(4), .PARK_CPU(1)) dut2 (
    .sys_clk(sys_clk), .reset(reset), .clken(clken), .cpureq(cpureq), .dbgreq(dbgreq),
    .intreq(intreq), .idle(idle), .ack(ack), .cpubm(cpubm2), .dbggnt(dbggnt2),
    .intgnt(intgnt2), .intbm(intbm2), .notdbg(notdbg2), .relreq(relreq2), .owner(owner2));

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected output word: {cpubm, dbggnt, intgnt, intbm, notdbg, relreq, owner}
  function automatic logic [W-1:0] ex(input logic c, input logic d, input logic [2:0] g,
                                      input logic r);
    logic [1:0] o;
    o = d ? 2'd2 : ((|g) ? 2'd3 : (c ? 2'd1 : 2'd0));
    return {c, d, g, |g, ~d, r, o};
  endfunction

  // driver + scoreboard: push expectation, advance one edge, compare after it
  task automatic cyc(input string tag, input logic [W-1:0] e, input bit sel2);
    logic [W-1:0] got, want;
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    got  = sel2 ? {cpubm2, dbggnt2, intgnt2, intbm2, notdbg2, relreq2, owner2}
                : {cpubm1, dbggnt1, intgnt1, intbm1, notdbg1, relreq1, owner1};
    want = exp_q.pop_front();
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: got %b required %b", tag, got, want);
    end
  endtask

  logic [2:0] order[4];
  logic [W-1:0] zero_g;

  initial begin
    zero_g = ex(1'b0, 1'b0, 3'b000, 1'b0);
`ifdef BUS_ARB_RR_EN
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    reset = 1'b1; clken = 1'b1; cpureq = 1'b0; dbgreq = 1'b0;
    intreq = 3'b000; idle = 1'b1; ack = 1'b0;

    cyc("reset", ex(1, 0, 3'b000, 0), 0);
    cyc("reset_t2", ex(1, 0, 3'b000, 0), 1);
    reset = 1'b0;
    cyc("park_idle", ex(1, 0, 3'b000, 0), 0);

    // internal beats CPU, one dead cycle
    cpureq = 1'b1; intreq = 3'b010;
    cyc("turna_dead", zero_g, 0);
    cpureq = 1'b0;
    cyc("own_int1", ex(0, 0, 3'b010, 0), 0);
    intreq = 3'b000; idle = 1'b0;
    cyc("hold_busy1", ex(0, 0, 3'b010, 0), 0);
    cyc("hold_busy2", ex(0, 0, 3'b010, 0), 0);
    idle = 1'b1;
    cyc("release_int1", zero_g, 0);
    cyc("repark", ex(1, 0, 3'b000, 0), 0);

    // ack blocks arbitration
    intreq = 3'b100; ack = 1'b1;
    cyc("ack_blocks", ex(1, 0, 3'b000, 0), 0);
    ack = 1'b0;
    cyc("turna_int2", zero_g, 0);
    cyc("own_int2", ex(0, 0, 3'b100, 0), 0);
    intreq = 3'b000;
    cyc("rel_int2", zero_g, 0);
    cyc("repark2", ex(1, 0, 3'b000, 0), 0);

    // tenure limit with pending debug request
    intreq = 3'b001;
    cyc("turna_int0", zero_g, 0);
    cyc("own_int0", ex(0, 0, 3'b001, 0), 0);
    dbgreq = 1'b1;
    for (int i = 0; i < 3; i++) cyc("tenure_pre", ex(0, 0, 3'b001, 0), 0);
    cyc("relreq_set", ex(0, 0, 3'b001, 1), 0);
    cyc("relreq_hold", ex(0, 0, 3'b001, 1), 0);
    intreq = 3'b000;
    cyc("rel_int0", zero_g, 0);
    cyc("park_pre_dbg", ex(1, 0, 3'b000, 0), 0);
    cyc("turna_dbg", zero_g, 0);
    cyc("own_dbg", ex(0, 1, 3'b000, 0), 0);
    dbgreq = 1'b0;
    cyc("rel_dbg", zero_g, 0);
    cyc("repark3", ex(1, 0, 3'b000, 0), 0);

    // parked CPU as sole requester: no dead cycle, tenure still counted
    cpureq = 1'b1;
    cyc("cpu_direct", ex(1, 0, 3'b000, 0), 0);
    dbgreq = 1'b1;
    for (int i = 0; i < 3; i++) cyc("cpu_tenure_pre", ex(1, 0, 3'b000, 0), 0);
    cyc("cpu_relreq", ex(1, 0, 3'b000, 1), 0);
    cpureq = 1'b0; dbgreq = 1'b0;
    cyc("rel_cpu", zero_g, 0);
    cyc("repark4", ex(1, 0, 3'b000, 0), 0);

    // clock enable gating on the TURN=2 instance
    reset = 1'b1;
    cyc("reset_b", ex(1, 0, 3'b000, 0), 1);
    reset = 1'b0; intreq = 3'b001;
    cyc("t2_turna", zero_g, 1);
    clken = 1'b0;
    cyc("t2_frozen1", zero_g, 1);
    clken = 1'b1;
    cyc("t2_turna2", zero_g, 1);
    clken = 1'b0;
    cyc("t2_frozen2", zero_g, 1);
    clken = 1'b1;
    cyc("t2_own", ex(0, 0, 3'b001, 0), 1);
    clken = 1'b0; intreq = 3'b000;
    cyc("t2_frozen_own", ex(0, 0, 3'b001, 0), 1);
    clken = 1'b1;
    cyc("t2_turnb1", zero_g, 1);
    cyc("t2_turnb2", zero_g, 1);
    cyc("t2_park", ex(1, 0, 3'b000, 0), 1);

    // internal grant order with all internal masters requesting
    reset = 1'b1;
    cyc("reset_c", ex(1, 0, 3'b000, 0), 0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      intreq = 3'b111;
      cyc("order_turna", zero_g, 0);
      cyc("order_grant", ex(0, 0, order[r], 0), 0);
      intreq = 3'b111 & ~order[r];
      cyc("order_release", zero_g, 0);
      intreq = 3'b111;
      cyc("order_park", ex(1, 0, 3'b000, 0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
